rx_frame_ctrl: RTL and testbench

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

---
 rtl/pcie_sym_pkg.sv | 27 ++
 rtl/sat_cnt8.sv | 20 ++
 rtl/rx_frame_ctrl.sv | 159 +++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_sym_pkg.sv
// Purpose: symbol codes and receive-framer state encoding shared by the RX framer and demux bench.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package pcie_sym_pkg;

    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_SKP = 8'h1C;
    localparam logic [7:0] SYM_STP = 8'hFB;
    localparam logic [7:0] SYM_SDP = 8'h5C;
    localparam logic [7:0] SYM_END = 8'hFD;
    localparam logic [7:0] SYM_IDL = 8'h7C;

    typedef enum logic [2:0] {
        UNALIGNED,
        ALIGNED,
        ORD_SET,
        TLP,
        DLLP
    } rx_state_t;

    // True for any of the six control symbols; everything else is payload data.
    function automatic logic is_ctrl(input logic [7:0] sym);
        return (sym == SYM_COM) || (sym == SYM_SKP) || (sym == SYM_STP) ||
               (sym == SYM_SDP) || (sym == SYM_END) || (sym == SYM_IDL);
    endfunction

endpackage

// File: rtl/sat_cnt8.sv
// Purpose: 8-bit event counter that sticks at FF instead of wrapping.
// Latency: count reflects an increment one clk after inc is sampled.
// Backpressure: none; inc is honoured every cycle it is high.
module sat_cnt8 (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       inc,
    output logic [7:0] cnt
);

    // Count up on inc, hold once the ceiling is reached.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt <= 8'h00;
        end else if (inc && (cnt != 8'hFF)) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Purpose: lane alignment plus TLP/DLLP framing of a demuxed symbol stream, with SKP and error counters.
// Latency: every output is registered, one clk after the symbol is sampled.
// Backpressure: none; valid_in=0 cycles freeze all state and zero the strobe outputs.
module rx_frame_ctrl
    import pcie_sym_pkg::*;
#(
    parameter int MAX_TLP  = 16,
    parameter int DLLP_LEN = 2
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       valid_in,
    input  logic [7:0] data_in,
    output logic       link_up,
    output logic       tlp_valid,
    output logic       dllp_valid,
    output logic [7:0] data_out,
    output logic       sop,
    output logic       eop,
    output logic       frame_err,
    output logic [7:0] skp_cnt,
    output logic [7:0] err_cnt
);

    // Payload counter must hold the larger of the two length limits.
    localparam int MAX_LEN = (MAX_TLP > DLLP_LEN) ? MAX_TLP : DLLP_LEN;
    localparam int PCNT_W  = $clog2(MAX_LEN + 2);
    localparam logic [PCNT_W-1:0] MAX_TLP_C  = PCNT_W'(MAX_TLP);
    localparam logic [PCNT_W-1:0] DLLP_LEN_C = PCNT_W'(DLLP_LEN);

    rx_state_t         state, state_nxt;
    logic [1:0]        com_cnt, com_cnt_nxt;
    logic [PCNT_W-1:0] pay_cnt, pay_cnt_nxt;
    logic [PCNT_W-1:0] pay_lim;
    logic              end_ok;
    logic              link_up_nxt, tlp_valid_nxt, dllp_valid_nxt;
    logic              sop_nxt, eop_nxt, err_nxt, skp_inc;
    logic [7:0]        data_out_nxt;

    // A TLP may carry 1..MAX_TLP bytes; a DLLP must carry exactly DLLP_LEN.
    assign pay_lim = (state == TLP) ? MAX_TLP_C : DLLP_LEN_C;
    assign end_ok  = (state == TLP) ? (pay_cnt != '0) : (pay_cnt == DLLP_LEN_C);

    // State register and registered outputs.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state      <= UNALIGNED;
            com_cnt    <= 2'd0;
            pay_cnt    <= '0;
            link_up    <= 1'b0;
            tlp_valid  <= 1'b0;
            dllp_valid <= 1'b0;
            sop        <= 1'b0;
            eop        <= 1'b0;
            frame_err  <= 1'b0;
            data_out   <= 8'h00;
        end else begin
            state      <= state_nxt;
            com_cnt    <= com_cnt_nxt;
            pay_cnt    <= pay_cnt_nxt;
            link_up    <= link_up_nxt;
            tlp_valid  <= tlp_valid_nxt;
            dllp_valid <= dllp_valid_nxt;
            sop        <= sop_nxt;
            eop        <= eop_nxt;
            frame_err  <= err_nxt;
            data_out   <= data_out_nxt;
        end
    end

    // Next-state and next-output decode; an idle input cycle holds everything.
    always_comb begin
        state_nxt      = state;
        com_cnt_nxt    = com_cnt;
        pay_cnt_nxt    = pay_cnt;
        link_up_nxt    = link_up;
        data_out_nxt   = data_out;
        tlp_valid_nxt  = 1'b0;
        dllp_valid_nxt = 1'b0;
        sop_nxt        = 1'b0;
        eop_nxt        = 1'b0;
        err_nxt        = 1'b0;
        skp_inc        = 1'b0;
        if (valid_in) begin
            unique case (state)
                UNALIGNED: begin
                    if (data_in == SYM_COM) begin
                        if (com_cnt == 2'd3) begin
                            com_cnt_nxt = 2'd0;
                            link_up_nxt = 1'b1;
                            state_nxt   = ORD_SET;
                        end else begin
                            com_cnt_nxt = com_cnt + 2'd1;
                        end
                    end else begin
                        com_cnt_nxt = 2'd0;
                    end
                end
                ALIGNED: begin
                    unique case (data_in)
                        SYM_STP: begin state_nxt = TLP;  pay_cnt_nxt = '0; end
                        SYM_SDP: begin state_nxt = DLLP; pay_cnt_nxt = '0; end
                        SYM_COM: state_nxt = ORD_SET;
                        SYM_SKP, SYM_IDL: state_nxt = ALIGNED;
                        default: err_nxt = 1'b1;
                    endcase
                end
                ORD_SET: begin
                    unique case (data_in)
                        SYM_COM: state_nxt = ORD_SET;
                        SYM_SKP: skp_inc   = 1'b1;
                        SYM_STP: begin state_nxt = TLP;  pay_cnt_nxt = '0; end
                        SYM_SDP: begin state_nxt = DLLP; pay_cnt_nxt = '0; end
                        SYM_IDL: state_nxt = ALIGNED;
                        default: begin err_nxt = 1'b1; state_nxt = ALIGNED; end
                    endcase
                end
                TLP, DLLP: begin
                    if (!is_ctrl(data_in)) begin
                        // A byte past the length limit kills the frame and is not delivered.
                        if (pay_cnt >= pay_lim) begin
                            err_nxt   = 1'b1;
                            state_nxt = ALIGNED;
                        end else begin
                            data_out_nxt   = data_in;
                            tlp_valid_nxt  = (state == TLP);
                            dllp_valid_nxt = (state == DLLP);
                            sop_nxt        = (pay_cnt == '0);
                            pay_cnt_nxt    = pay_cnt + PCNT_W'(1);
                        end
                    end else if ((data_in == SYM_END) && end_ok) begin
                        eop_nxt   = 1'b1;
                        state_nxt = ALIGNED;
                    end else begin
                        // Offending STP/SDP is consumed here, never re-parsed as a new frame.
                        err_nxt   = 1'b1;
                        state_nxt = ALIGNED;
                    end
                end
                default: state_nxt = UNALIGNED;
            endcase
        end
    end

    sat_cnt8 u_skp_cnt (
        .clk     (clk),
        .reset_L (reset_L),
        .inc     (skp_inc),
        .cnt     (skp_cnt)
    );

    sat_cnt8 u_err_cnt (
        .clk     (clk),
        .reset_L (reset_L),
        .inc     (err_nxt),
        .cnt     (err_cnt)
    );

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Purpose: self-checking bench for rx_frame_ctrl using a per-symbol expected-output scoreboard.
// Latency: expectations are due one clk after the symbol they belong to is sampled.
// Backpressure: idle cycles are driven with valid_in=0 and a control code on data_in.
module tb_rx_frame_ctrl;
    import pcie_sym_pkg::*;

    localparam logic [5:0] F_LU  = 6'b100000;
    localparam logic [5:0] F_TV  = 6'b010000;
    localparam logic [5:0] F_DV  = 6'b001000;
    localparam logic [5:0] F_SOP = 6'b000100;
    localparam logic [5:0] F_EOP = 6'b000010;
    localparam logic [5:0] F_ERR = 6'b000001;
    localparam logic [5:0] L     = F_LU;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       valid_in;
    logic [7:0] data_in;
    logic       link_up, tlp_valid, dllp_valid, sop, eop, frame_err;
    logic [7:0] data_out, skp_cnt, err_cnt;

    typedef struct {
        int         due;
        logic [7:0] sym;
        logic [5:0] flags;
        logic [7:0] d;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    rx_frame_ctrl #(.MAX_TLP(16), .DLLP_LEN(2)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .link_up    (link_up),
        .tlp_valid  (tlp_valid),
        .dllp_valid (dllp_valid),
        .data_out   (data_out),
        .sop        (sop),
        .eop        (eop),
        .frame_err  (frame_err),
        .skp_cnt    (skp_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Advance to the next falling edge and retire every scoreboard entry now due.
    task automatic step();
        @(negedge clk);
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            exp_t       e;
            logic [5:0] got;
            e   = sb_q.pop_front();
            got = {link_up, tlp_valid, dllp_valid, sop, eop, frame_err};
            n_checks++;
            if (got !== e.flags) begin
                n_fail++;
                $display("FAIL sb_flags cyc=%0d sym=%h got={lu,tv,dv,sop,eop,err}=%b exp=%b",
                         cyc, e.sym, got, e.flags);
            end
            if ((e.flags & (F_TV | F_DV)) != 6'd0) begin
                n_checks++;
                if (data_out !== e.d) begin
                    n_fail++;
                    $display("FAIL sb_data cyc=%0d sym=%h got=%h exp=%h", cyc, e.sym, data_out, e.d);
                end
            end
        end
    endtask

    task automatic send(input logic [7:0] sym, input logic [5:0] fl, input logic [7:0] d = 8'h00);
        step();
        valid_in = 1'b1;
        data_in  = sym;
        sb_q.push_back('{due: cyc + 1, sym: sym, flags: fl, d: d});
    endtask

    // Idle cycle: data_in carries STP to show it is ignored without valid_in.
    task automatic idle(input logic [5:0] fl);
        step();
        valid_in = 1'b0;
        data_in  = SYM_STP;
        sb_q.push_back('{due: cyc + 1, sym: 8'h00, flags: fl, d: 8'h00});
    endtask

    task automatic drain();
        for (int i = 0; i < 4 && sb_q.size() > 0; i++) begin
            step();
            valid_in = 1'b0;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout got=%0d pending exp=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        reset_L  = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        #12;
        n_checks++;
        if ({link_up, tlp_valid, dllp_valid, sop, eop, frame_err, data_out, skp_cnt, err_cnt} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b exp=0",
                     {link_up, tlp_valid, dllp_valid, sop, eop, frame_err, data_out, skp_cnt, err_cnt});
        end
        @(negedge clk);
        reset_L = 1'b1;
        idle(6'd0);
        idle(6'd0);
        drain();
    endtask

    task automatic test_align();
        send(SYM_COM, 6'd0); send(SYM_COM, 6'd0); send(8'h00, 6'd0);
        send(SYM_COM, 6'd0); send(8'h00, 6'd0);
        for (int i = 0; i < 3; i++) send(SYM_COM, 6'd0);
        send(SYM_COM, L);
        drain();
        n_checks++;
        if (link_up !== 1'b1) begin
            n_fail++;
            $display("FAIL align_link_up got=%b exp=1", link_up);
        end
    endtask

    task automatic test_tlp();
        send(SYM_STP, L);
        send(8'h01, L | F_TV | F_SOP, 8'h01);
        send(8'h02, L | F_TV, 8'h02);
        send(SYM_END, L | F_EOP);
        drain();
        n_checks++;
        if (err_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL tlp_err_cnt got=%h exp=00", err_cnt);
        end
    endtask

    task automatic test_valid_gap();
        send(SYM_SDP, L);
        send(8'h41, L | F_DV | F_SOP, 8'h41);
        idle(L);
        send(8'h42, L | F_DV, 8'h42);
        send(SYM_END, L | F_EOP);
        drain();
    endtask

    task automatic test_skp();
        send(SYM_COM, L);
        for (int i = 0; i < 12; i++) send(SYM_SKP, L);
        send(SYM_IDL, L);
        drain();
        n_checks++;
        if (skp_cnt !== 8'h0C) begin
            n_fail++;
            $display("FAIL skp_count got=%h exp=0C", skp_cnt);
        end
    endtask

    task automatic test_frame_len();
        send(SYM_STP, L);
        for (int i = 3; i <= 12; i++)
            send(8'(i), L | F_TV | ((i == 3) ? F_SOP : 6'd0), 8'(i));
        send(SYM_END, L | F_EOP);
        send(SYM_SDP, L);
        send(8'h0D, L | F_DV | F_SOP, 8'h0D);
        send(SYM_END, L | F_ERR);
        drain();
        n_checks++;
        if (err_cnt !== 8'h01) begin
            n_fail++;
            $display("FAIL short_dllp_err_cnt got=%h exp=01", err_cnt);
        end
    endtask

    task automatic test_overflow();
        send(SYM_STP, L);
        for (int i = 1; i <= 16; i++)
            send(8'(8'h20 + i), L | F_TV | ((i == 1) ? F_SOP : 6'd0), 8'(8'h20 + i));
        send(8'h31, L | F_ERR);
        send(SYM_IDL, L);
        drain();
        n_checks++;
        if (err_cnt !== 8'h02) begin
            n_fail++;
            $display("FAIL overflow_err_cnt got=%h exp=02", err_cnt);
        end
    endtask

    task automatic test_ctrl_errors();
        send(SYM_STP, L);
        send(SYM_END, L | F_ERR);
        send(8'h55, L | F_ERR);
        send(SYM_STP, L);
        send(8'h01, L | F_TV | F_SOP, 8'h01);
        send(SYM_SDP, L | F_ERR);
        send(8'h02, L | F_ERR);
        send(SYM_COM, L);
        send(8'h55, L | F_ERR);
        send(SYM_SDP, L);
        send(8'h51, L | F_DV | F_SOP, 8'h51);
        send(8'h52, L | F_DV, 8'h52);
        send(8'h53, L | F_ERR);
        drain();
        n_checks++;
        if (err_cnt !== 8'h08) begin
            n_fail++;
            $display("FAIL ctrl_err_cnt got=%h exp=08", err_cnt);
        end
    endtask

    task automatic test_saturate();
        send(SYM_COM, L);
        for (int i = 0; i < 260; i++) send(SYM_SKP, L);
        send(SYM_IDL, L);
        for (int i = 0; i < 250; i++) send(8'h55, L | F_ERR);
        drain();
        n_checks++;
        if (skp_cnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL skp_saturate got=%h exp=FF", skp_cnt);
        end
        n_checks++;
        if (err_cnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL err_saturate got=%h exp=FF", err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        send(SYM_STP, L);
        send(8'h61, L | F_TV | F_SOP, 8'h61);
        step();
        valid_in = 1'b0;
        #1;
        n_checks++;
        if ({tlp_valid, data_out} !== {1'b1, 8'h61}) begin
            n_fail++;
            $display("FAIL pre_reset_byte got=%b/%h exp=1/61", tlp_valid, data_out);
        end
        reset_L = 1'b0;
        #1;
        n_checks++;
        if ({link_up, tlp_valid, dllp_valid, sop, eop, frame_err, data_out, skp_cnt, err_cnt} !== 30'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs got=%b exp=0",
                     {link_up, tlp_valid, dllp_valid, sop, eop, frame_err, data_out, skp_cnt, err_cnt});
        end
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        send(SYM_STP, 6'd0); send(8'h05, 6'd0); send(SYM_END, 6'd0); send(SYM_SDP, 6'd0);
        send(SYM_IDL, 6'd0); send(SYM_SKP, 6'd0); send(8'h00, 6'd0); send(SYM_END, 6'd0);
        drain();
        n_checks++;
        if ({link_up, eop, skp_cnt, err_cnt} !== 18'd0) begin
            n_fail++;
            $display("FAIL unaligned_after_reset got=%b exp=0", {link_up, eop, skp_cnt, err_cnt});
        end
        for (int i = 0; i < 3; i++) send(SYM_COM, 6'd0);
        send(SYM_COM, L);
        send(SYM_STP, L);
        send(8'h70, L | F_TV | F_SOP, 8'h70);
        send(SYM_END, L | F_EOP);
        drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_align();
        test_tlp();
        test_valid_gap();
        test_skp();
        test_frame_len();
        test_overflow();
        test_ctrl_errors();
        test_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
